// File: rtl/adc_conversion_reader.sv
// adc_conversion_reader: one ADC conversion plus SPI readout per accepted
// trigger. The result is presented on an AXI-Stream style master port.
// Missed triggers and overwritten words set sticky status bits.
module adc_conversion_reader #(
    parameter int DATA_WIDTH = 18,  // 1..32, shifted in MSB first
    parameter int CNV_CYCLES = 30,  // >= 1
    parameter int SCK_HALF   = 2    // >= 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  trigger,
    output logic                  cnv,
    output logic                  sck,
    input  logic                  sdi,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  missed_trig,
    output logic                  overflow
);

    localparam int MAXC = (CNV_CYCLES > SCK_HALF) ? CNV_CYCLES : SCK_HALF;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CNV_LAST  = CW'(CNV_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(SCK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;         // cycles within CNV or SCK half-period
    logic [BW-1:0]         bit_cnt, bit_cnt_n; // bit periods completed in SHIFT
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [DATA_WIDTH:0]   shift_in;
    logic [DATA_WIDTH-1:0] tdata_n;
    logic                  cnv_n, sck_n, tvalid_n, busy_n, missed_n, overflow_n;

    // Append the sampled bit at the LSB; the top bit falls off the wide vector.
    assign shift_in = {shreg, sdi};

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        sck_n      = 1'b0;
        tdata_n    = m_axis_tdata;
        // A word handed over on this edge drops tvalid. A load below overrides this.
        tvalid_n   = m_axis_tvalid & ~m_axis_tready;
        missed_n   = missed_trig;
        overflow_n = overflow;

        if (trigger && state != IDLE)
            missed_n = 1'b1;

        case (state)
            IDLE: begin
                if (trigger) begin
                    state_n = CONVERT;
                    cnt_n   = '0;
                end
            end
            CONVERT: begin
                if (cnt == CNV_LAST) begin
                    state_n   = SHIFT;
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            SHIFT: begin
                sck_n = sck;
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!sck) begin
                        // Rising SCK edge: sample the ADC's data line.
                        sck_n   = 1'b1;
                        shreg_n = shift_in[DATA_WIDTH-1:0];
                    end else begin
                        sck_n = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state_n  = IDLE;
                            tdata_n  = shreg;
                            tvalid_n = 1'b1;
                            if (m_axis_tvalid && !m_axis_tready)
                                overflow_n = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + BW'(1);
                        end
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        cnv_n  = (state_n == CONVERT);
        busy_n = (state_n != IDLE);
    end

    // State and output registers. An asynchronous reset aborts any read in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            cnv           <= 1'b0;
            sck           <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            missed_trig   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_cnt       <= bit_cnt_n;
            shreg         <= shreg_n;
            cnv           <= cnv_n;
            sck           <= sck_n;
            m_axis_tdata  <= tdata_n;
            m_axis_tvalid <= tvalid_n;
            busy          <= busy_n;
            missed_trig   <= missed_n;
            overflow      <= overflow_n;
        end
    end

endmodule

// File: tb/tb_adc_conversion_reader.sv
// tb_adc_conversion_reader: directed bench with a cycle-position reference model,
// a behavioural ADC, and a second instance using the smallest legal parameters.
module tb_adc_conversion_reader;

    localparam int DW  = 18;
    localparam int CNV = 30;
    localparam int SH  = 2;
    localparam int T   = CNV + 2 * SH * DW + 1;  // 103

    logic          clk, resetn;
    logic          trigger, cnv, sck, sdi, tvalid, tready, busy, missed, overflow;
    logic [DW-1:0] tdata;
    logic          trigger1, cnv1, sck1, sdi1, tvalid1, tready1, busy1, missed1, overflow1;
    logic [0:0]    tdata1;

    int n_pass = 0;
    int n_chk  = 0;

    adc_conversion_reader #(.DATA_WIDTH(DW), .CNV_CYCLES(CNV), .SCK_HALF(SH)) dut (
        .clk(clk), .resetn(resetn), .trigger(trigger), .cnv(cnv), .sck(sck), .sdi(sdi),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .busy(busy), .missed_trig(missed), .overflow(overflow));

    adc_conversion_reader #(.DATA_WIDTH(1), .CNV_CYCLES(1), .SCK_HALF(1)) dut1 (
        .clk(clk), .resetn(resetn), .trigger(trigger1), .cnv(cnv1), .sck(sck1), .sdi(sdi1),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1),
        .busy(busy1), .missed_trig(missed1), .overflow(overflow1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural ADC: presents the MSB when CNV falls and the next bit after each SCK fall.
    logic [DW-1:0] adc_word = '0;
    int            adc_idx  = DW - 1;
    logic          cnv_q = 1'b0, sck_q = 1'b0;
    always @(negedge clk) begin
        if (cnv_q && !cnv)      adc_idx <= DW - 1;
        else if (sck_q && !sck) adc_idx <= adc_idx - 1;
        cnv_q <= cnv;
        sck_q <= sck;
    end
    assign sdi = (adc_idx >= 0 && adc_idx < DW) ? adc_word[adc_idx] : 1'b0;

    // Reference model: m_pos = cycles since the accepted trigger (1..T-1 while busy).
    bit            m_active = 1'b0;
    int            m_pos    = 0;
    logic [DW-1:0] m_word   = '0, m_tdata = '0;
    bit            m_tvalid = 1'b0, m_missed = 1'b0, m_ovf = 1'b0;
    bit            m_load, e_cnv, e_sck;
    assign m_load = m_active && (m_pos == T - 1);
    assign e_cnv  = m_active && (m_pos <= CNV);
    assign e_sck  = m_active && (m_pos > CNV) && (((m_pos - CNV - 1) % (2 * SH)) >= SH);

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0; m_pos <= 0; m_tvalid <= 1'b0;
            m_tdata <= '0; m_missed <= 1'b0; m_ovf <= 1'b0;
        end else begin
            m_missed <= m_missed | (m_active & trigger);
            m_tvalid <= m_load ? 1'b1 : (m_tvalid & ~tready);
            if (m_load) m_tdata <= m_word;
            if (m_load && m_tvalid && !tready) m_ovf <= 1'b1;
            if (m_active) begin
                m_pos <= m_pos + 1;
                if (m_pos == T - 1) m_active <= 1'b0;
            end else if (trigger) begin
                m_active <= 1'b1;
                m_pos    <= 1;
                m_word   <= adc_word;
            end
        end
    end

    // Compare the main instance against the model on every cycle.
    always @(negedge clk) begin
        chk("cnv", cnv, e_cnv);
        chk("sck", sck, e_sck);
        chk("busy", busy, m_active);
        chk("tvalid", tvalid, m_tvalid);
        if (m_tvalid) chk("tdata", tdata, m_tdata);
        chk("missed_trig", missed, m_missed);
        chk("overflow", overflow, m_ovf);
    end

    logic [DW-1:0] words [10] = '{18'h2A5C3, 18'h00000, 18'h3FFFF, 18'h15555, 18'h2AAAA,
                                  18'h00001, 18'h20000, 18'h1E0F0, 18'h0BEEF, 18'h31337};

    initial begin
        resetn = 1'b0; trigger = 1'b0; tready = 1'b1;
        trigger1 = 1'b0; tready1 = 1'b1; sdi1 = 1'b1;
        tick(3);
        chk("rst_cnv", cnv, 1'b0);
        chk("rst_sck", sck, 1'b0);
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tdata", tdata, 18'h0);
        resetn = 1'b1;
        tick(2);

        // Corner instance: T = 4
        trigger1 = 1'b1; tick(1); trigger1 = 1'b0;
        chk("c_cnv1", cnv1, 1'b1);
        tick(1);
        chk("c_cnv2", cnv1, 1'b0);
        chk("c_sck2", sck1, 1'b0);
        tick(1);
        chk("c_sck3", sck1, 1'b1);
        chk("c_tvalid3", tvalid1, 1'b0);
        tick(1);
        chk("c_tvalid4", tvalid1, 1'b1);
        chk("c_tdata4", tdata1, 1'b1);
        chk("c_busy4", busy1, 1'b0);
        sdi1 = 1'b0; trigger1 = 1'b1; tick(1); trigger1 = 1'b0;
        chk("c_consumed", tvalid1, 1'b0);
        tick(3);
        chk("c_tvalid_b", tvalid1, 1'b1);
        chk("c_tdata_b", tdata1, 1'b0);
        chk("c_overflow", overflow1, 1'b0);
        tick(2);

        // Single conversion
        adc_word = 18'h2A5C3; trigger = 1'b1; tick(1); trigger = 1'b0;
        chk("s_cnv1", cnv, 1'b1);
        tick(29);
        chk("s_cnv30", cnv, 1'b1);
        tick(1);
        chk("s_cnv31", cnv, 1'b0);
        chk("s_sck31", sck, 1'b0);
        tick(2);
        chk("s_sck33", sck, 1'b1);
        tick(69);
        chk("s_tvalid102", tvalid, 1'b0);
        tick(1);
        chk("s_tvalid103", tvalid, 1'b1);
        chk("s_tdata103", tdata, 18'h2A5C3);
        tick(1);
        chk("s_tvalid104", tvalid, 1'b0);

        // Back-to-back at the minimum trigger period
        for (int i = 0; i < 10; i++) begin
            adc_word = words[i]; trigger = 1'b1; tick(1); trigger = 1'b0;
            tick(T - 1);
        end
        chk("b_tvalid", tvalid, 1'b1);
        chk("b_tdata", tdata, 18'h31337);
        chk("b_missed", missed, 1'b0);
        tick(1);

        // Early trigger is ignored
        adc_word = 18'h15A5A; trigger = 1'b1; tick(1); trigger = 1'b0;
        tick(59);
        trigger = 1'b1; tick(1); trigger = 1'b0;
        chk("e_missed", missed, 1'b1);
        tick(42);
        chk("e_tvalid", tvalid, 1'b1);
        chk("e_tdata", tdata, 18'h15A5A);
        tick(1);
        chk("e_busy", busy, 1'b0);
        chk("e_cnv", cnv, 1'b0);

        // Backpressure and overwrite
        tready = 1'b0;
        adc_word = 18'h00001; trigger = 1'b1; tick(1); trigger = 1'b0;
        tick(T - 1);
        chk("p_tvalid1", tvalid, 1'b1);
        chk("p_tdata1", tdata, 18'h00001);
        chk("p_ovf1", overflow, 1'b0);
        adc_word = 18'h3FFFF; trigger = 1'b1; tick(1); trigger = 1'b0;
        chk("p_hold", tdata, 18'h00001);
        tick(T - 1);
        chk("p_tvalid2", tvalid, 1'b1);
        chk("p_tdata2", tdata, 18'h3FFFF);
        chk("p_ovf2", overflow, 1'b1);
        tready = 1'b1;
        tick(1);
        chk("p_drop", tvalid, 1'b0);
        chk("p_ovf_sticky", overflow, 1'b1);
        tick(1);

        // Reset mid-read
        adc_word = 18'h0F0F0; trigger = 1'b1; tick(1); trigger = 1'b0;
        tick(49);
        chk("r_sck_pre", sck, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("r_cnv", cnv, 1'b0);
        chk("r_sck", sck, 1'b0);
        chk("r_busy", busy, 1'b0);
        chk("r_tvalid", tvalid, 1'b0);
        chk("r_missed", missed, 1'b0);
        chk("r_ovf", overflow, 1'b0);
        tick(5);
        resetn = 1'b1;
        tick(1);
        adc_word = 18'h2BEEF; trigger = 1'b1; tick(1); trigger = 1'b0;
        tick(T - 1);
        chk("r_tvalid_after", tvalid, 1'b1);
        chk("r_tdata_after", tdata, 18'h2BEEF);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
